// File: rtl/mac_combiner_pipe.sv
// rtl/mac_combiner_pipe.sv - two-stage partial-product combiner (single/dual/quad per 4-lane group)
module mac_combiner_pipe #(
  parameter int N_LANES = 4,
  parameter int INT_W   = 16,
  parameter int ACC_W   = 16,
  parameter int MIN_W   = 8,
  parameter int SIGNED  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               cfg_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_LANES*INT_W-1:0] partials_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_cfg,
  output logic [N_LANES*ACC_W-1:0] out_data
);

  localparam int N_GROUPS = N_LANES / 4;
  localparam int P_W      = 2 * ACC_W;
  localparam int Q_W      = 4 * ACC_W;

  logic                      s1_valid;
  logic [1:0]                s1_cfg;
  logic [N_GROUPS*P_W-1:0]   s1_p01;
  logic [N_GROUPS*P_W-1:0]   s1_p23;
  logic [N_LANES*ACC_W-1:0]  s1_single;

  logic                      s1_ready;
  logic                      s2_ready;
  logic [N_GROUPS*P_W-1:0]   p01_d;
  logic [N_GROUPS*P_W-1:0]   p23_d;
  logic [N_LANES*ACC_W-1:0]  single_d;
  logic [N_LANES*ACC_W-1:0]  comb_d;

  function automatic logic [P_W-1:0] ext_p(input logic [INT_W-1:0] p);
    logic [P_W-1:0] r;
    r = {P_W{(SIGNED != 0) && p[INT_W-1]}};
    r[INT_W-1:0] = p;
    return r;
  endfunction

  function automatic logic [Q_W-1:0] ext_q(input logic [P_W-1:0] v);
    logic [Q_W-1:0] r;
    r = {Q_W{(SIGNED != 0) && v[P_W-1]}};
    r[P_W-1:0] = v;
    return r;
  endfunction

  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = en && s1_ready;

  // Stage 1: extend each partial once, form the two pair sums of every group.
  always_comb begin
    logic [P_W-1:0] e0, e1, e2, e3, el;
    p01_d    = '0;
    p23_d    = '0;
    single_d = '0;
    e0 = '0;
    e1 = '0;
    e2 = '0;
    e3 = '0;
    el = '0;
    for (int i = 0; i < N_LANES; i++) begin
      el = ext_p(partials_in[i*INT_W +: INT_W]);
      single_d[i*ACC_W +: ACC_W] = el[ACC_W-1:0];
    end
    for (int g = 0; g < N_GROUPS; g++) begin
      e0 = ext_p(partials_in[(4*g+0)*INT_W +: INT_W]);
      e1 = ext_p(partials_in[(4*g+1)*INT_W +: INT_W]);
      e2 = ext_p(partials_in[(4*g+2)*INT_W +: INT_W]);
      e3 = ext_p(partials_in[(4*g+3)*INT_W +: INT_W]);
      p01_d[g*P_W +: P_W] = e0 + (e1 << MIN_W);
      p23_d[g*P_W +: P_W] = e2 + (e3 << MIN_W);
    end
  end

  // Stage 2: each group picks its result by the beat's own mode; 2'b11 falls to single.
  always_comb begin
    comb_d = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      case (s1_cfg)
        2'b01:   comb_d[g*Q_W +: Q_W] = {s1_p23[g*P_W +: P_W], s1_p01[g*P_W +: P_W]};
        2'b10:   comb_d[g*Q_W +: Q_W] = ext_q(s1_p01[g*P_W +: P_W])
                                      + (ext_q(s1_p23[g*P_W +: P_W]) << (2*MIN_W));
        default: comb_d[g*Q_W +: Q_W] = s1_single[g*Q_W +: Q_W];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_cfg    <= 2'b00;
      s1_p01    <= '0;
      s1_p23    <= '0;
      s1_single <= '0;
      out_valid <= 1'b0;
      out_cfg   <= 2'b00;
      out_data  <= '0;
    end else if (en) begin
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_cfg    <= cfg_in;
          s1_p01    <= p01_d;
          s1_p23    <= p23_d;
          s1_single <= single_d;
        end
      end
      // Output register only reloads with a real beat, so a drained pipe keeps its last data.
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_cfg  <= s1_cfg;
          out_data <= comb_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_combiner_pipe.sv
// tb/tb_mac_combiner_pipe.sv - scoreboard bench for mac_combiner_pipe
module tb_mac_combiner_pipe;

  typedef struct {
    logic [1:0]   cfg;
    logic [127:0] data;
    int           acc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic         in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
  logic [1:0]   cfg_a = 2'b00, out_cfg_a;
  logic [63:0]  part_a = '0, out_data_a;

  logic         in_valid_bc = 1'b0, in_ready_b, in_ready_c, out_valid_b, out_valid_c;
  logic         out_ready_bc = 1'b1;
  logic [1:0]   cfg_bc = 2'b00, out_cfg_b, out_cfg_c;
  logic [63:0]  part_b = '0, out_data_b;
  logic [127:0] part_c = '0, out_data_c;

  logic         held_a = 1'b0;
  logic [63:0]  held_data = '0;
  logic [1:0]   held_cfg = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_combiner_pipe #(.N_LANES(4), .SIGNED(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cfg_in(cfg_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .partials_in(part_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_cfg(out_cfg_a), .out_data(out_data_a));

  mac_combiner_pipe #(.N_LANES(4), .SIGNED(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cfg_in(cfg_bc), .in_valid(in_valid_bc), .in_ready(in_ready_b),
    .partials_in(part_b), .out_valid(out_valid_b), .out_ready(out_ready_bc),
    .out_cfg(out_cfg_b), .out_data(out_data_b));

  mac_combiner_pipe #(.N_LANES(8), .SIGNED(0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .cfg_in(cfg_bc), .in_valid(in_valid_bc), .in_ready(in_ready_c),
    .partials_in(part_c), .out_valid(out_valid_c), .out_ready(out_ready_bc),
    .out_cfg(out_cfg_c), .out_data(out_data_c));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [1:0] cfg, input logic [63:0] data, input logic [63:0] exp, input int lat);
    bit done = 0;
    cfg_a = cfg;
    part_a = data;
    in_valid_a = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready_a) begin
        qa.push_back('{cfg, {64'd0, exp}, cyc, lat});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid_a = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_a_timeout: got no in_ready expected accept within 40 cycles");
    end
  endtask

  task automatic send_bc(input logic [1:0] cfg, input logic [63:0] db, input logic [63:0] eb,
                         input logic [127:0] dc, input logic [127:0] ec);
    bit done = 0;
    cfg_bc = cfg;
    part_b = db;
    part_c = dc;
    in_valid_bc = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready_b && in_ready_c) begin
        qb.push_back('{cfg, {64'd0, eb}, cyc, 2});
        qc.push_back('{cfg, ec, cyc, 2});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid_bc = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_bc_timeout: got no in_ready expected accept within 40 cycles");
    end
  endtask

  // Monitor A also verifies that a stalled or frozen output never moves.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_a = 1'b0;
    end else begin
      if (held_a) begin
        chk("a_hold_valid", out_valid_a, 1);
        chk("a_hold_data", out_data_a, held_data);
        chk("a_hold_cfg", out_cfg_a, held_cfg);
      end
      held_a    = out_valid_a && !(out_ready_a && en);
      held_data = out_data_a;
      held_cfg  = out_cfg_a;
      if (out_valid_a && out_ready_a && en) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected: got beat %h expected none", out_data_a);
        end else begin
          e = qa.pop_front();
          chk("a_data", out_data_a, e.data);
          chk("a_cfg", out_cfg_a, e.cfg);
          if (e.lat != 0) chk("a_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && en && out_valid_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got beat %h expected none", out_data_b);
      end else begin
        e = qb.pop_front();
        chk("b_data", out_data_b, e.data);
        chk("b_cfg", out_cfg_b, e.cfg);
        chk("b_latency", cyc - e.acc, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && en && out_valid_c) begin
      if (qc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c_unexpected: got beat %h expected none", out_data_c);
      end else begin
        e = qc.pop_front();
        chk("c_data", out_data_c, e.data);
        chk("c_cfg", out_cfg_c, e.cfg);
        chk("c_latency", cyc - e.acc, e.lat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid_a, 0);
    chk("reset_out_data", out_data_a, 0);
    chk("reset_out_cfg", out_cfg_a, 0);
    chk("reset_in_ready", in_ready_a, 1);
    chk("reset_c_out_valid", out_valid_c, 0);
    @(posedge clk);
    #1;

    // Back-to-back beats, each with its own mode, full throughput.
    send_a(2'b00, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 2);
    send_a(2'b01, 64'h0000_FFFF_0001_00FF, 64'h0000_FFFF_0000_01FF, 2);
    send_a(2'b10, 64'h0001_0001_0001_0001, 64'h0000_0000_0101_0101, 2);
    send_a(2'b11, 64'hBEEF_1234_8000_00FF, 64'hBEEF_1234_8000_00FF, 2);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure mid-stream with mixed modes.
    send_a(2'b00, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 0);
    out_ready_a = 1'b0;
    send_a(2'b01, 64'h0000_FFFF_0001_00FF, 64'h0000_FFFF_0000_01FF, 0);
    cfg_a = 2'b10;
    part_a = 64'h0001_0001_0001_0001;
    in_valid_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_full", in_ready_a, 0);
      @(posedge clk);
      #1;
    end
    out_ready_a = 1'b1;
    send_a(2'b10, 64'h0001_0001_0001_0001, 64'h0000_0000_0101_0101, 0);
    send_a(2'b00, 64'hBEEF_1234_8000_00FF, 64'hBEEF_1234_8000_00FF, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("stream_drained", qa.size(), 0);

    // Enable low for two cycles while a beat sits in stage 1.
    send_a(2'b01, 64'h0000_FFFF_0001_00FF, 64'h0000_FFFF_0000_01FF, 4);
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("en_low_in_ready", in_ready_a, 0);
      chk("en_low_out_valid", out_valid_a, 0);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset with two beats in flight: they must vanish.
    out_ready_a = 1'b0;
    send_a(2'b10, 64'h0001_0001_0001_0001, 64'h0000_0000_0101_0101, 0);
    send_a(2'b01, 64'h0000_FFFF_0001_00FF, 64'h0000_FFFF_0000_01FF, 0);
    rst = 1'b1;
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready_a = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid_a, 0);
    chk("midrst_out_data", out_data_a, 0);
    chk("midrst_out_cfg", out_cfg_a, 0);
    repeat (5) @(posedge clk);
    #1;

    // Signed 4-lane instance and 8-lane instance, driven together.
    send_bc(2'b01, 64'h0000_8000_FFFF_0000, 64'hFFFF_8000_FFFF_FF00,
            128'h0001_0001_0001_0001_0000_FFFF_0001_00FF,
            128'h0000_0101_0000_0101_0000_FFFF_0000_01FF);
    send_bc(2'b10, 64'hFFFF_0000_0000_0000, 64'hFFFF_FFFF_FF00_0000,
            128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF,
            128'h0000_0000_0000_0000_0000_0100_FFFF_FEFF);
    repeat (5) @(posedge clk);
    #1;

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
